alu_result_capture: RTL and testbench

ALU_RESULT_CAPTURE -- requirements
Module: alu_result_capture

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_cap_fifo.sv | 55 +++++
 rtl/alu_result_capture.sv | 103 ++++++++++
 tb/tb_alu_result_capture.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions: default data width, op codes,
//               3-bit condition codes and the condition evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SHL  = 4'h5,
        OP_SHR  = 4'h6,
        OP_PASS = 4'h7
    } alu_op_e;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_VS = 3'b101;
    localparam logic [2:0] COND_VC = 3'b110;
    localparam logic [2:0] COND_MI = 3'b111;

    function automatic logic cond_eval(input logic [2:0] sel, input logic z,
                                       input logic v, input logic n);
        logic r;
        case (sel)
            COND_AL: r = 1'b1;
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_LT: r = n ^ v;
            COND_GE: r = ~(n ^ v);
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_MI: r = n;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cap_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cap_fifo
// Description : 2-entry in-order FIFO with valid/ready on both sides; the
//               write side stays closed until the first edge after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cap_fifo #(
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              r_alive;
    logic              w_push;
    logic              w_pop;

    // Ready depends only on registered state: no path from i_ready.
    assign o_ready = r_alive && (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_alive  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/alu_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_capture
// Description : Buffers ALU results/flags, commits flags on pop and evaluates
//               a condition on the committed flags. Optional statistics
//               counters are enabled with ALU_CAP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_z,
    input  logic             in_v,
    input  logic             in_n,
    input  logic             in_flag_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    input  logic [2:0]       cond_sel,
    output logic             cond_true
`ifdef ALU_CAP_STATS_EN
    ,
    output logic [15:0]      commit_cnt,
    output logic [15:0]      zero_cnt
`endif
);

    localparam int ENTRY_W = WIDTH + 4;

    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_head;
    logic               w_pop;
    logic               r_flag_z;
    logic               r_flag_v;
    logic               r_flag_n;

    // Entry layout: {result, z, v, n, flag_we}
    assign w_in_entry = {in_result, in_z, in_v, in_n, in_flag_we};

    alu_cap_fifo #(
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_entry),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_head)
    );

    assign w_pop      = out_valid && out_ready;
    assign out_result = w_head[ENTRY_W-1:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_pop && w_head[0]) begin
            r_flag_z <= w_head[3];
            r_flag_v <= w_head[2];
            r_flag_n <= w_head[1];
        end
    end

    assign flag_z    = r_flag_z;
    assign flag_v    = r_flag_v;
    assign flag_n    = r_flag_n;
    assign cond_true = cond_eval(cond_sel, r_flag_z, r_flag_v, r_flag_n);

`ifdef ALU_CAP_STATS_EN
    logic [15:0] r_commit_cnt;
    logic [15:0] r_zero_cnt;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit_cnt <= 16'd0;
            r_zero_cnt   <= 16'd0;
        end else if (w_pop) begin
            if (r_commit_cnt != 16'hFFFF) r_commit_cnt <= r_commit_cnt + 16'd1;
            if (w_head[3] && (r_zero_cnt != 16'hFFFF)) r_zero_cnt <= r_zero_cnt + 16'd1;
        end
    end

    assign commit_cnt = r_commit_cnt;
    assign zero_cnt   = r_zero_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_capture.sv
`timescale 1ns/1ps
// Self-checking bench for alu_result_capture: a queue-based reference model
// tracks buffered entries, committed flags and optional statistics.
module tb_alu_result_capture;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_result;
    logic         in_z, in_v, in_n, in_flag_we;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         flag_z, flag_v, flag_n;
    logic [2:0]   cond_sel;
    logic         cond_true;
`ifdef ALU_CAP_STATS_EN
    logic [15:0]  commit_cnt;
    logic [15:0]  zero_cnt;
`endif

    always #5 clk = ~clk;

    alu_result_capture #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_z       (in_z),
        .in_v       (in_v),
        .in_n       (in_n),
        .in_flag_we (in_flag_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_n     (flag_n),
        .cond_sel   (cond_sel),
        .cond_true  (cond_true)
`ifdef ALU_CAP_STATS_EN
        ,
        .commit_cnt (commit_cnt),
        .zero_cnt   (zero_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0] res;
        logic         z, v, n, we;
    } ent_t;

    ent_t mq[$];
    logic m_z, m_v, m_n, m_alive;
    int   m_commit, m_zero;
    int   total = 0;
    int   bad   = 0;

    function automatic logic m_cond(input int sel, input logic z, input logic v, input logic n);
        case (sel)
            0: return 1'b1;
            1: return z;
            2: return !z;
            3: return n != v;
            4: return n == v;
            5: return v;
            6: return !v;
            default: return n;
        endcase
    endfunction

    task automatic model_reset();
        rst_n = 1'b0;
        mq.delete();
        m_z = 0; m_v = 0; m_n = 0; m_alive = 0;
        m_commit = 0; m_zero = 0;
    endtask

    // Advance one clock and update the model from the handshakes seen.
    task automatic cycle();
        bit   do_push, do_pop;
        ent_t e, h;
        do_push = rst_n && in_valid && m_alive && (mq.size() < 2);
        do_pop  = rst_n && out_ready && (mq.size() > 0);
        e.res = in_result; e.z = in_z; e.v = in_v; e.n = in_n; e.we = in_flag_we;
        @(posedge clk);
        #1;
        if (!rst_n) return;
        if (do_pop) begin
            h = mq.pop_front();
            if (h.we) begin m_z = h.z; m_v = h.v; m_n = h.n; end
            if (m_commit < 65535) m_commit++;
            if (h.z && m_zero < 65535) m_zero++;
        end
        if (do_push) mq.push_back(e);
        m_alive = 1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] r, input logic z,
                         input logic ov, input logic n, input logic we);
        in_valid = v; in_result = r; in_z = z; in_v = ov; in_n = n; in_flag_we = we;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        model_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {flag_z, flag_v, flag_n}); end
        repeat (2) cycle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready_pre_edge got=%b want=0", in_ready); end
        cycle();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_single();
        cond_sel  = 3'b001;
        out_ready = 1'b1;
        drive(1, 16'h0006, 0, 0, 0, 1);
        cycle();
        drive(0, 16'h0000, 0, 0, 0, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b want=1", out_valid); end
        total++; if (out_result !== 16'h0006) begin bad++; $display("FAIL single_out_result got=%h want=0006", out_result); end
        cycle();
        total++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin bad++; $display("FAIL single_flags got=%b want=000", {flag_z, flag_v, flag_n}); end
        total++; if (cond_true !== 1'b0) begin bad++; $display("FAIL single_cond_eq got=%b want=0", cond_true); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_fill_stall();
        out_ready = 1'b0;
        drive(1, 16'h0000, 1, 0, 0, 1);
        cycle();
        drive(1, 16'hFFFF, 0, 0, 1, 1);
        cycle();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
        drive(1, 16'h1234, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b want=0", i, in_ready); end
            total++; if (out_result !== 16'h0000) begin bad++; $display("FAIL stall_head[%0d] got=%h want=0000", i, out_result); end
            total++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin bad++; $display("FAIL stall_flags[%0d] got=%b want=000", i, {flag_z, flag_v, flag_n}); end
        end
        out_ready = 1'b1;
        cycle();
        total++; if (flag_z !== 1'b1) begin bad++; $display("FAIL pop1_flag_z got=%b want=1", flag_z); end
        total++; if (out_result !== 16'hFFFF) begin bad++; $display("FAIL pop1_head got=%h want=ffff", out_result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pop1_in_ready got=%b want=1", in_ready); end
        cycle();
        drive(0, 16'h0000, 0, 0, 0, 0);
        total++; if (out_result !== 16'h1234) begin bad++; $display("FAIL late_push_head got=%h want=1234", out_result); end
        total++; if ({flag_z, flag_v, flag_n} !== 3'b001) begin bad++; $display("FAIL pop2_flags got=%b want=001", {flag_z, flag_v, flag_n}); end
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_drained got=%b want=0", out_valid); end
        total++; if ({flag_z, flag_v, flag_n} !== 3'b001) begin bad++; $display("FAIL we0_flags got=%b want=001", {flag_z, flag_v, flag_n}); end
    endtask

    task automatic test_flag_hold();
        out_ready = 1'b0;
        drive(1, 16'h0000, 1, 0, 0, 1);
        cycle();
        drive(1, 16'hFFFF, 0, 0, 0, 0);
        cycle();
        drive(0, 16'h0000, 0, 0, 0, 0);
        out_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            cycle();
            total++; if (flag_z !== 1'b1) begin bad++; $display("FAIL hold_flag_z[%0d] got=%b want=1", p, flag_z); end
            cond_sel = 3'b001; #1;
            total++; if (cond_true !== 1'b1) begin bad++; $display("FAIL hold_eq[%0d] got=%b want=1", p, cond_true); end
            cond_sel = 3'b010; #1;
            total++; if (cond_true !== 1'b0) begin bad++; $display("FAIL hold_ne[%0d] got=%b want=0", p, cond_true); end
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        out_ready = 1'b0;
        drive(1, 16'h0100, 0, 0, 0, 0);
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 16'h0101 + 16'(i), 1'($urandom), 1'($urandom), 1'($urandom), 1);
            cycle();
            exp = 16'h0101 + 16'(i);
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_count1[%0d] got=v%b r%b want=v1 r1", i, out_valid, in_ready); end
            total++; if (out_result !== exp) begin bad++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, out_result, exp); end
            total++; if ({flag_z, flag_v, flag_n} !== {m_z, m_v, m_n}) begin bad++; $display("FAIL b2b_flags[%0d] got=%b want=%b", i, {flag_z, flag_v, flag_n}, {m_z, m_v, m_n}); end
        end
        drive(0, 16'h0000, 0, 0, 0, 0);
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_cond();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1, 16'($urandom), k[2], k[1], k[0], 1);
            cycle();
            drive(0, 16'h0000, 0, 0, 0, 0);
            cycle();
            total++; if ({flag_z, flag_v, flag_n} !== k[2:0]) begin bad++; $display("FAIL cond_flags[%0d] got=%b want=%b", k, {flag_z, flag_v, flag_n}, k[2:0]); end
            for (int s = 0; s < 8; s++) begin
                cond_sel = 3'(s); #1;
                total++; if (cond_true !== m_cond(s, k[2], k[1], k[0])) begin bad++; $display("FAIL cond_sel%0d_flags%0d got=%b want=%b", s, k, cond_true, m_cond(s, k[2], k[1], k[0])); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            out_ready = 1'($urandom);
            cond_sel  = 3'($urandom);
            cycle();
            total++; if (out_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_out_valid[%0d] got=%b want=%b", i, out_valid, mq.size() > 0); end
            total++; if (in_ready !== (mq.size() < 2)) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b want=%b", i, in_ready, mq.size() < 2); end
            if (mq.size() > 0) begin
                total++; if (out_result !== mq[0].res) begin bad++; $display("FAIL rnd_out_result[%0d] got=%h want=%h", i, out_result, mq[0].res); end
            end
            total++; if ({flag_z, flag_v, flag_n} !== {m_z, m_v, m_n}) begin bad++; $display("FAIL rnd_flags[%0d] got=%b want=%b", i, {flag_z, flag_v, flag_n}, {m_z, m_v, m_n}); end
            total++; if (cond_true !== m_cond(int'(cond_sel), m_z, m_v, m_n)) begin bad++; $display("FAIL rnd_cond[%0d] got=%b want=%b", i, cond_true, m_cond(int'(cond_sel), m_z, m_v, m_n)); end
`ifdef ALU_CAP_STATS_EN
            total++; if (commit_cnt !== 16'(m_commit) || zero_cnt !== 16'(m_zero)) begin bad++; $display("FAIL rnd_stats[%0d] got=%0d/%0d want=%0d/%0d", i, commit_cnt, zero_cnt, m_commit, m_zero); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(1, 16'h00AA, 1, 1, 1, 1);
        cycle();
        drive(0, 16'h0000, 0, 0, 0, 0);
        cycle();
        out_ready = 1'b0;
        drive(1, 16'h0011, 0, 0, 0, 1);
        cycle();
        drive(1, 16'h0022, 0, 0, 0, 1);
        cycle();
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=v%b r%b want=v1 r0", out_valid, in_ready); end
        total++; if ({flag_z, flag_v, flag_n} !== 3'b111) begin bad++; $display("FAIL mid_pre_flags got=%b want=111", {flag_z, flag_v, flag_n}); end
        model_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b want=0", out_valid); end
        total++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin bad++; $display("FAIL mid_rst_flags got=%b want=000", {flag_z, flag_v, flag_n}); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=0", in_ready); end
        drive(0, 16'h0000, 0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (2) cycle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rel_in_ready[%0d] got=%b want=1", i, in_ready); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rel_stale[%0d] got=%b want=0", i, out_valid); end
            total++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin bad++; $display("FAIL mid_rel_flags[%0d] got=%b want=000", i, {flag_z, flag_v, flag_n}); end
        end
    endtask

`ifdef ALU_CAP_STATS_EN
    task automatic test_stats();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'($urandom), (i == 1), 0, 0, 1);
            cycle();
        end
        drive(0, 16'h0000, 0, 0, 0, 0);
        cycle();
        total++; if (commit_cnt !== 16'd3) begin bad++; $display("FAIL stats_commit got=%0d want=3", commit_cnt); end
        total++; if (zero_cnt !== 16'd1) begin bad++; $display("FAIL stats_zero got=%0d want=1", zero_cnt); end
    endtask
`endif

    initial begin
        rst_n     = 1'b1;
        out_ready = 1'b0;
        cond_sel  = 3'b000;
        drive(0, 16'h0000, 0, 0, 0, 0);
        test_reset();
        test_single();
        test_fill_stall();
        test_flag_hold();
        test_back_to_back();
        test_cond();
        test_random();
        test_reset_mid();
`ifdef ALU_CAP_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
